// File: rtl/imm_gen_pkg.sv
// Shared definitions for the pipelined RISC-V immediate generator:
// opcode constants, immediate format codes, skid-buffer state encoding.
package imm_gen_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_W   = 7;

    localparam logic [OPC_W-1:0] OP_LOAD   = 7'h03;
    localparam logic [OPC_W-1:0] OP_IMM    = 7'h13;
    localparam logic [OPC_W-1:0] OP_IMM32  = 7'h1B;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'h67;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'h23;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'h63;
    localparam logic [OPC_W-1:0] OP_LUI    = 7'h37;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'h17;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'h6F;
    localparam logic [OPC_W-1:0] OP_OP     = 7'h33;
    localparam logic [OPC_W-1:0] OP_SYSTEM = 7'h73;

    typedef enum logic [2:0] {
        FMT_NONE     = 3'd0,
        FMT_I        = 3'd1,
        FMT_S        = 3'd2,
        FMT_B        = 3'd3,
        FMT_U        = 3'd4,
        FMT_J        = 3'd5,
        FMT_R        = 3'd6,
        FMT_CSR_UIMM = 3'd7
    } imm_fmt_e;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    // Decode side-band carried alongside the immediate
    typedef struct packed {
        imm_fmt_e fmt;
        logic     illegal;
    } imm_meta_t;

    localparam imm_meta_t META_RST = '{fmt: FMT_NONE, illegal: 1'b0};

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle of the immediate generator: instruction in, immediate out.
// slave = generator side, master = producer/consumer side.
interface imm_gen_pipe_if
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) ();

    logic               in_valid_i;
    logic               in_ready_o;
    logic [INSTR_W-1:0] instr_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [XLEN-1:0]    imm_o;
    imm_fmt_e           imm_fmt_o;
    logic               illegal_o;

    modport slave (
        input  in_valid_i,
        input  instr_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output imm_o,
        output imm_fmt_o,
        output illegal_o
    );

    modport master (
        output in_valid_i,
        output instr_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  imm_o,
        input  imm_fmt_o,
        input  illegal_o
    );

endinterface

// File: rtl/imm_decode.sv
// Combinational opcode -> {immediate, format, illegal} decoder.
// Optional: define IMM_GEN_CSR_UIMM_EN to decode CSR*I zero-extended uimm
// and I-format SYSTEM immediates; otherwise SYSTEM is reported illegal.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [INSTR_W-1:0] i_instr,
    output logic [XLEN-1:0]    o_imm,
    output imm_fmt_e           o_fmt,
    output logic               o_illegal
);

    logic signed [31:0] w_imm32;
    imm_fmt_e           w_fmt;
    logic               w_illegal;

    // Format selection; every format is built as a signed 32-bit value first
    always_comb begin
        w_imm32   = 32'sd0;
        w_fmt     = FMT_NONE;
        w_illegal = 1'b1;
        case (i_instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR: begin
                w_imm32   = {{20{i_instr[31]}}, i_instr[31:20]};
                w_fmt     = FMT_I;
                w_illegal = 1'b0;
            end
            OP_IMM32: begin
                if (XLEN == 64) begin
                    w_imm32   = {{20{i_instr[31]}}, i_instr[31:20]};
                    w_fmt     = FMT_I;
                    w_illegal = 1'b0;
                end
            end
            OP_STORE: begin
                w_imm32   = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
                w_fmt     = FMT_S;
                w_illegal = 1'b0;
            end
            OP_BRANCH: begin
                w_imm32   = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                             i_instr[30:25], i_instr[11:8], 1'b0};
                w_fmt     = FMT_B;
                w_illegal = 1'b0;
            end
            OP_LUI, OP_AUIPC: begin
                w_imm32   = {i_instr[31:12], 12'b0};
                w_fmt     = FMT_U;
                w_illegal = 1'b0;
            end
            OP_JAL: begin
                w_imm32   = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                             i_instr[20], i_instr[30:21], 1'b0};
                w_fmt     = FMT_J;
                w_illegal = 1'b0;
            end
            OP_OP: begin
                w_fmt     = FMT_R;
                w_illegal = 1'b0;
            end
            OP_SYSTEM: begin
`ifdef IMM_GEN_CSR_UIMM_EN
                if (i_instr[14]) begin
                    w_imm32 = {27'b0, i_instr[19:15]};
                    w_fmt   = FMT_CSR_UIMM;
                end else begin
                    w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
                    w_fmt   = FMT_I;
                end
                w_illegal = 1'b0;
`else
                w_fmt     = FMT_NONE;
                w_illegal = 1'b1;
`endif
            end
            default: begin
                w_fmt     = FMT_NONE;
                w_illegal = 1'b1;
            end
        endcase
    end

    // Signed size cast sign-extends to 64 bits when XLEN=64
    assign o_imm     = XLEN'(w_imm32);
    assign o_fmt     = w_fmt;
    assign o_illegal = w_illegal;

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decoder followed by a main register and an
// optional skid register behind valid/ready handshakes.
// SKID_EN=1: 2-entry skid, in_ready_o from a flop. SKID_EN=0: single register.
// Optional feature macro (decoder): IMM_GEN_CSR_UIMM_EN.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    imm_gen_pipe_if.slave bus
);

    logic [XLEN-1:0] w_dec_imm;
    imm_meta_t       w_dec_meta;
    imm_fmt_e        w_dec_fmt;
    logic            w_dec_illegal;

    skid_state_e     r_state;
    skid_state_e     w_state_nxt;
    logic            r_out_valid;
    logic            r_in_ready;
    logic [XLEN-1:0] r_main_imm;
    imm_meta_t       r_main_meta;
    logic [XLEN-1:0] r_skid_imm;
    imm_meta_t       r_skid_meta;

    logic            w_in_ready;
    logic            w_acc;
    logic            w_deq;
    logic            w_main_ld;
    logic            w_main_shift;
    logic            w_skid_ld;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .i_instr   (bus.instr_i),
        .o_imm     (w_dec_imm),
        .o_fmt     (w_dec_fmt),
        .o_illegal (w_dec_illegal)
    );

    assign w_dec_meta = '{fmt: w_dec_fmt, illegal: w_dec_illegal};

    // Without the skid register, ready must look through to the consumer
    assign w_in_ready = SKID_EN ? r_in_ready : (!r_out_valid || bus.out_ready_i);
    assign w_acc      = bus.in_valid_i && w_in_ready;
    assign w_deq      = r_out_valid && bus.out_ready_i;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SKID_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and data-move strobes; flush wins over any accept
    always_comb begin
        w_state_nxt  = r_state;
        w_main_ld    = 1'b0;
        w_main_shift = 1'b0;
        w_skid_ld    = 1'b0;
        if (flush_i) begin
            w_state_nxt = SKID_EMPTY;
        end else begin
            case (r_state)
                SKID_EMPTY: begin
                    if (w_acc) begin
                        w_state_nxt = SKID_ONE;
                        w_main_ld   = 1'b1;
                    end
                end
                SKID_ONE: begin
                    if (w_acc && w_deq) begin
                        w_main_ld   = 1'b1;
                    end else if (w_acc) begin
                        w_state_nxt = SKID_FULL;
                        w_skid_ld   = 1'b1;
                    end else if (w_deq) begin
                        w_state_nxt = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (w_deq) begin
                        w_state_nxt  = SKID_ONE;
                        w_main_shift = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = SKID_EMPTY;
                end
            endcase
        end
    end

    // Output/skid registers; reset and flush return everything to idle values
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_main_imm  <= '0;
            r_main_meta <= META_RST;
            r_skid_imm  <= '0;
            r_skid_meta <= META_RST;
        end else begin
            r_out_valid <= (w_state_nxt != SKID_EMPTY);
            r_in_ready  <= (w_state_nxt != SKID_FULL);
            if (w_main_ld) begin
                r_main_imm  <= w_dec_imm;
                r_main_meta <= w_dec_meta;
            end else if (w_main_shift) begin
                r_main_imm  <= r_skid_imm;
                r_main_meta <= r_skid_meta;
            end
            if (w_skid_ld) begin
                r_skid_imm  <= w_dec_imm;
                r_skid_meta <= w_dec_meta;
            end
        end
    end

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_valid_o = r_out_valid;
    assign bus.imm_o       = r_main_imm;
    assign bus.imm_fmt_o   = r_main_meta.fmt;
    assign bus.illegal_o   = r_main_meta.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomized self-checking bench for imm_gen_pipe (XLEN=32, skid enabled)
// plus a standalone XLEN=64 decoder, against a queue-based reference model.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(XLEN)) bus ();

    imm_gen_pipe #(
        .XLEN    (XLEN),
        .SKID_EN (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .bus     (bus.slave)
    );

    logic [31:0] instr64;
    logic [63:0] imm64;
    imm_fmt_e    fmt64;
    logic        ill64;

    imm_decode #(.XLEN(64)) u_dec64 (
        .i_instr   (instr64),
        .o_imm     (imm64),
        .o_fmt     (fmt64),
        .o_illegal (ill64)
    );

    typedef struct {
        logic [63:0] imm;
        imm_fmt_e    fmt;
        bit          ill;
    } exp_t;

    exp_t q[$];
    bit   clr_chk;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic [6:0] ops[13] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63, 7'h37,
                            7'h17, 7'h6F, 7'h33, 7'h73, 7'h7F, 7'h3B};

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference decode from the architectural immediate definitions
    function automatic exp_t ref_decode(input logic [31:0] ins, input int xlen);
        exp_t   e;
        longint v;
        v     = 0;
        e.fmt = FMT_NONE;
        e.ill = 1'b1;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67: begin v = longint'($signed(ins[31:20])); e.fmt = FMT_I; e.ill = 1'b0; end
            7'h1B: if (xlen == 64) begin v = longint'($signed(ins[31:20])); e.fmt = FMT_I; e.ill = 1'b0; end
            7'h23: begin v = longint'($signed({ins[31:25], ins[11:7]})); e.fmt = FMT_S; e.ill = 1'b0; end
            7'h63: begin v = 2 * longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})); e.fmt = FMT_B; e.ill = 1'b0; end
            7'h37, 7'h17: begin v = 4096 * longint'($signed(ins[31:12])); e.fmt = FMT_U; e.ill = 1'b0; end
            7'h6F: begin v = 2 * longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})); e.fmt = FMT_J; e.ill = 1'b0; end
            7'h33: begin e.fmt = FMT_R; e.ill = 1'b0; end
`ifdef IMM_GEN_CSR_UIMM_EN
            7'h73: begin
                if (ins[14]) begin v = longint'(ins[19:15]); e.fmt = FMT_CSR_UIMM; end
                else begin v = longint'($signed(ins[31:20])); e.fmt = FMT_I; end
                e.ill = 1'b0;
            end
`endif
            default: ;
        endcase
        e.imm = 64'(v);
        if (xlen == 32) e.imm = {32'b0, e.imm[31:0]};
        return e;
    endfunction

    // One cycle: drive at negedge, check outputs against the model, update the model
    task automatic step(input bit v, input logic [31:0] ins, input bit ordy, input bit fl, input bit rs);
        exp_t d;
        bit   rdy_m;
        @(negedge clk);
        rst             = rs;
        flush           = fl;
        bus.in_valid_i  = v;
        bus.instr_i     = ins;
        bus.out_ready_i = ordy;
        instr64         = ins;
        #1;
        rdy_m = (q.size() < 2);
        chk_eq("out_valid", 64'(bus.out_valid_o), 64'(q.size() > 0));
        chk_eq("in_ready", 64'(bus.in_ready_o), 64'(rdy_m));
        if (q.size() > 0) begin
            chk_eq("imm", 64'(bus.imm_o), q[0].imm);
            chk_eq("fmt", 64'(bus.imm_fmt_o), 64'(q[0].fmt));
            chk_eq("illegal", 64'(bus.illegal_o), 64'(q[0].ill));
        end else if (clr_chk) begin
            chk_eq("clr_imm", 64'(bus.imm_o), 64'd0);
            chk_eq("clr_fmt", 64'(bus.imm_fmt_o), 64'(FMT_NONE));
            chk_eq("clr_illegal", 64'(bus.illegal_o), 64'd0);
        end
        clr_chk = 1'b0;
        d = ref_decode(ins, 64);
        chk_eq("dec64_imm", imm64, d.imm);
        chk_eq("dec64_fmt", 64'(fmt64), 64'(d.fmt));
        chk_eq("dec64_illegal", 64'(ill64), 64'(d.ill));
        if (rs || fl) begin
            q.delete();
            clr_chk = 1'b1;
        end else begin
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (v && rdy_m) q.push_back(ref_decode(ins, 32));
        end
    endtask

    // Directly check the head of the output against fixed expected values
    task automatic chk_head(input string tag, input logic [31:0] imm, input imm_fmt_e fmt, input bit ill);
        @(posedge clk);
        #1;
        chk_eq({tag, "_valid"}, 64'(bus.out_valid_o), 64'd1);
        chk_eq({tag, "_imm"}, 64'(bus.imm_o), 64'(imm));
        chk_eq({tag, "_fmt"}, 64'(bus.imm_fmt_o), 64'(fmt));
        chk_eq({tag, "_illegal"}, 64'(bus.illegal_o), 64'(ill));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r      = $urandom;
        r[6:0] = ops[$urandom_range(0, 12)];
        return r;
    endfunction

    initial begin
        rst             = 1'b1;
        flush           = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.instr_i     = '0;
        bus.out_ready_i = 1'b0;
        instr64         = '0;
        repeat (3) @(posedge clk);
        clr_chk = 1'b1;
        step(0, 32'h0, 1, 0, 0);

        // Directed decode cases
        step(1, 32'hFFF00093, 1, 0, 0); chk_head("addi", 32'hFFFFFFFF, FMT_I, 1'b0);
        step(1, 32'hFE20AE23, 1, 0, 0); chk_head("sw",   32'hFFFFFFFC, FMT_S, 1'b0);
        step(1, 32'hFE000CE3, 1, 0, 0); chk_head("beq",  32'hFFFFFFF8, FMT_B, 1'b0);
        step(1, 32'h123450B7, 1, 0, 0); chk_head("lui",  32'h12345000, FMT_U, 1'b0);
        step(1, 32'h001000EF, 1, 0, 0); chk_head("jal",  32'h00000800, FMT_J, 1'b0);
        step(1, 32'h0000007F, 1, 0, 0); chk_head("op7f", 32'h00000000, FMT_NONE, 1'b1);
        step(1, 32'hFFF0009B, 1, 0, 0); chk_head("addiw32", 32'h00000000, FMT_NONE, 1'b1);
`ifdef IMM_GEN_CSR_UIMM_EN
        step(1, 32'h340FD0F3, 1, 0, 0); chk_head("csrrwi", 32'h0000001F, FMT_CSR_UIMM, 1'b0);
`else
        step(1, 32'h340FD0F3, 1, 0, 0); chk_head("csrrwi", 32'h00000000, FMT_NONE, 1'b1);
`endif
        step(0, 32'h0, 1, 0, 0);

        // XLEN=64 decoder boundaries
        instr64 = 32'h800000B7; #1;
        chk_eq("lui64_imm", imm64, 64'hFFFFFFFF80000000);
        instr64 = 32'hFFF0009B; #1;
        chk_eq("addiw64_imm", imm64, 64'hFFFFFFFFFFFFFFFF);
        chk_eq("addiw64_fmt", 64'(fmt64), 64'(FMT_I));

        // Back-pressure: three offered, two held, released in order
        step(1, 32'h00100093, 0, 0, 0);
        step(1, 32'h00200113, 0, 0, 0);
        step(1, 32'h00300193, 0, 0, 0);
        step(1, 32'h00300193, 0, 0, 0);
        step(1, 32'h00300193, 1, 0, 0);
        step(1, 32'h00300193, 1, 0, 0);
        step(0, 32'h0, 1, 0, 0);
        step(0, 32'h0, 1, 0, 0);

        // Flush while full with a same-cycle offer
        step(1, 32'h00400213, 0, 0, 0);
        step(1, 32'h00500293, 0, 0, 0);
        step(1, 32'h00600313, 0, 1, 0);
        step(0, 32'h0, 1, 0, 0);
        step(0, 32'h0, 1, 0, 0);

        // Reset in the middle of traffic
        step(1, 32'h00700393, 0, 0, 0);
        step(1, 32'h00800413, 1, 0, 1);
        step(0, 32'h0, 1, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
        end
        repeat (3) step(0, 32'h0, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
